// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core run-control logic: sequencer state
// encoding, the saturation limit of the instruction counter, and a
// counter-width helper.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_STEP    = 3'd2,
        ST_IN_WAIT = 3'd3,
        ST_HALTED  = 3'd4
    } seq_state_e;

    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int ctr_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/exec_sequencer_btn_conditioner.sv
// Button conditioner: two-flop synchroniser, stability counter and a
// registered one-cycle pulse on each accepted 0->1 transition.
module btn_conditioner
    import core_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pulse
);

    localparam int CW = ctr_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic          stable_dly_q, stable_dly_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next-state: synchronise, count consecutive disagreeing cycles, then accept.
    always_comb begin
        sync1_d      = btn_raw;
        sync2_d      = sync1_q;
        stable_d     = stable_q;
        cnt_d        = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        // The pulse is taken from the accepted level one cycle after it
        // changes, so it is a clean registered strobe.
        stable_dly_d = stable_q;
        pulse_d      = stable_q & ~stable_dly_q;
    end

    // Register all conditioner state; reset returns to an accepted level of 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            pulse_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            pulse_q      <= pulse_d;
            cnt_q        <= cnt_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/exec_sequencer.sv
// Run-control sequencer: converts the board clock into single-cycle
// instruction enables in free-run or single-step mode, stalls on input
// instructions until confirmed, and freezes on halt.
module exec_sequencer
    import core_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 25000000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        MODE_RUN,
    input  logic        STEP_BTN,
    input  logic        CONFIRM_BTN,
    input  logic        HALT,
    input  logic        IN_REQ,
    input  logic        OUT_REQ,
    output logic        CPU_EN,
    output logic        OUT_LATCH,
    output logic        WAIT_INPUT,
    output logic        HALTED,
    output logic [31:0] INSTR_COUNT
);

    localparam int DW = ctr_width(RUN_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);

    logic step_p;
    logic conf_p;

    seq_state_e    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic          cpu_en_q, cpu_en_d;
    logic          wait_q, wait_d;
    logic          halted_q, halted_d;
    logic [31:0]   instr_count_q, instr_count_d;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_btn (
        .clk    (CLOCK),
        .rst    (RESET),
        .btn_raw(STEP_BTN),
        .pulse  (step_p)
    );

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_conf_btn (
        .clk    (CLOCK),
        .rst    (RESET),
        .btn_raw(CONFIRM_BTN),
        .pulse  (conf_p)
    );

    // Where an enable is due: halt wins, then an input stall, otherwise the
    // enable fires and the sequencer moves to fire_state.
    function automatic seq_state_e issue_state(input logic halt, input logic in_req,
                                               input seq_state_e fire_state);
        if (halt)
            return ST_HALTED;
        else if (in_req)
            return ST_IN_WAIT;
        else
            return fire_state;
    endfunction

    // Next-state, divider, enable and counter logic.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        cpu_en_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The start press only selects the mode; no instruction commits.
                if (step_p) begin
                    state_d = MODE_RUN ? ST_RUN : ST_STEP;
                    div_d   = '0;
                end
            end

            ST_RUN: begin
                if (div_q == DIV_LAST) begin
                    div_d    = '0;
                    state_d  = issue_state(HALT, IN_REQ, MODE_RUN ? ST_RUN : ST_STEP);
                    cpu_en_d = ~HALT & ~IN_REQ;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end

            ST_STEP: begin
                // A mode switch beats a step press arriving in the same cycle.
                if (MODE_RUN) begin
                    state_d = ST_RUN;
                    div_d   = '0;
                end else if (step_p) begin
                    state_d  = issue_state(HALT, IN_REQ, ST_STEP);
                    cpu_en_d = ~HALT & ~IN_REQ;
                end
            end

            ST_IN_WAIT: begin
                // The stalled instruction is the input read itself, so it
                // commits on confirmation regardless of IN_REQ.
                if (conf_p) begin
                    cpu_en_d = 1'b1;
                    div_d    = '0;
                    state_d  = MODE_RUN ? ST_RUN : ST_STEP;
                end
            end

            ST_HALTED: begin
                state_d = ST_HALTED;
            end

            default: begin
                state_d = ST_IDLE;
                div_d   = '0;
            end
        endcase

        wait_d   = (state_d == ST_IN_WAIT);
        halted_d = (state_d == ST_HALTED);

        instr_count_d = instr_count_q;
        if (cpu_en_d && (instr_count_q != COUNT_MAX))
            instr_count_d = instr_count_q + 32'd1;
    end

    // State and registered outputs; reset discards any in-flight enable.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q       <= ST_IDLE;
            div_q         <= '0;
            cpu_en_q      <= 1'b0;
            wait_q        <= 1'b0;
            halted_q      <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            cpu_en_q      <= cpu_en_d;
            wait_q        <= wait_d;
            halted_q      <= halted_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign CPU_EN      = cpu_en_q;
    assign OUT_LATCH   = cpu_en_q & OUT_REQ;
    assign WAIT_INPUT  = wait_q;
    assign HALTED      = halted_q;
    assign INSTR_COUNT = instr_count_q;

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Run-control sequencer for the single-cycle core. It turns the free-running board clock into exactly-one-cycle instruction enables (`CPU_EN`) that gate the PC, register-file write, data-memory write and display latch. It supports free-run and single-step modes, stalls on input instructions until the operator confirms, and freezes on `HALT`. It sits between the board buttons/switches and the control unit, replacing the button-as-clock scheme.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a button level is accepted (≥1).
- `RUN_DIV`, default 25000000: board cycles between enables in run mode (≥1).
- `CLOCK` in 1: single clock for the whole block.
- `RESET` in 1: reset, synchronous, active-high; the only reset.
- `MODE_RUN` in 1: 1 = free run, 0 = single step; sampled every cycle, no debounce.
- `STEP_BTN` in 1: raw start/step button, active-high, asynchronous to `CLOCK`.
- `CONFIRM_BTN` in 1: raw input-confirm button, active-high, asynchronous.
- `HALT` in 1: control-unit decode of the current instruction as halt.
- `IN_REQ` in 1: current instruction reads `SWITCH`.
- `OUT_REQ` in 1: current instruction drives the display.
- `CPU_EN` out 1: one-cycle instruction commit enable.
- `OUT_LATCH` out 1: one-cycle display latch strobe.
- `WAIT_INPUT` out 1: core is stalled awaiting `CONFIRM_BTN`.
- `HALTED` out 1: core is frozen.
- `INSTR_COUNT` out 32: committed instruction count.

## Operation
- Reset: state IDLE, divider 0, debouncers cleared (stable level 0). All outputs 0, `INSTR_COUNT` 0.
- Each button passes through a conditioner: 2-flop synchroniser, then a stability counter. The accepted level updates after the synchronised level differs from it for `DEBOUNCE_CYCLES` consecutive cycles. A registered one-cycle pulse (`step_p` / `conf_p`) fires on an accepted 0→1 transition.
- Issue check, applied wherever an enable is due:
  - `HALT`=1 → HALTED, no enable.
  - else `IN_REQ`=1 → IN_WAIT, no enable.
  - else pulse `CPU_EN`.
  - `HALT` has priority over `IN_REQ`.
- IDLE: on `step_p`, go to RUN if `MODE_RUN`=1, else STEP. No enable is issued on this transition.
- RUN:
  - Divider counts 0..`RUN_DIV`-1 and is cleared on entry.
  - At the terminal count, apply the issue check, then wrap to 0.
  - If `MODE_RUN`=0 at the terminal count, apply the issue check, then go to STEP.
- STEP:
  - On `step_p`, apply the issue check.
  - If `MODE_RUN`=1, go to RUN (divider cleared). `MODE_RUN` takes priority over a same-cycle `step_p`.
- IN_WAIT:
  - `WAIT_INPUT`=1.
  - On `conf_p`, pulse `CPU_EN` unconditionally (the instruction is the IN), then return to RUN or STEP per `MODE_RUN`.
  - `step_p` is ignored here.
- HALTED: `HALTED`=1. Left only by `RESET`. Buttons are ignored.
- `OUT_LATCH` = `CPU_EN` AND `OUT_REQ`, same cycle.
- `INSTR_COUNT` increments on each `CPU_EN` and saturates at 0xFFFFFFFF.
- Button pulses that arrive in states that do not consume them are dropped, not queued.

## Timing
- All outputs are registered except `OUT_LATCH` (combinational AND of registered `CPU_EN` and `OUT_REQ`).
- Button latency: the pulse is high in cycle `DEBOUNCE_CYCLES`+3 after the first edge that samples the raw level high. `CPU_EN` follows one cycle after the consuming pulse.
- Run mode: first `CPU_EN` exactly `RUN_DIV` cycles after RUN entry, then every `RUN_DIV` cycles. With `RUN_DIV`=1, `CPU_EN` is high every cycle.
- `CPU_EN` is never high two consecutive cycles unless `RUN_DIV`=1.
- `HALT`/`IN_REQ` are sampled in the cycle the enable would have fired.
- `WAIT_INPUT`/`HALTED` assert the cycle after the state change.
- `RESET` mid-operation: next cycle is IDLE with all outputs 0. An in-flight pulse is discarded.

## Structure
- Shared package `core_ctrl_pkg` holds:
  - state encoding: IDLE=0, RUN=1, STEP=2, IN_WAIT=3, HALTED=4 (3-bit);
  - counter width helpers (clog2 of `DEBOUNCE_CYCLES` and `RUN_DIV`).
- Sub-module `btn_conditioner` (synchroniser + debounce + rising-edge pulse, parameter `DEBOUNCE_CYCLES`), instantiated twice.
- The FSM, divider and counter live in `exec_sequencer`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `RUN_DIV`=8.
- Reset, hold inputs 0 for 50 cycles → all outputs 0, state IDLE.
- `MODE_RUN`=1, press `STEP_BTN` 10 cycles → `CPU_EN` pulses every 8 cycles starting 8 cycles after RUN entry; after 5 pulses `INSTR_COUNT`=5.
- `MODE_RUN`=0, three 10-cycle presses with 3-cycle glitches between them → exactly 3 `CPU_EN` pulses, each 1 cycle after its step pulse; glitches produce none.
- Step mode with `IN_REQ`=1 → no `CPU_EN`, `WAIT_INPUT`=1; `CONFIRM_BTN` press → `CPU_EN` once, `WAIT_INPUT`=0, `INSTR_COUNT`+1.
- Run mode, assert `HALT` and `IN_REQ` together at a terminal count → `HALTED`=1, `WAIT_INPUT`=0, no further `CPU_EN` for 100 cycles despite presses; `RESET` → IDLE, count 0.
- `OUT_REQ`=1 during a run → `OUT_LATCH` coincides with every `CPU_EN`. Force the count to 0xFFFFFFFE and run 3 enables → it holds at 0xFFFFFFFF.
